// File: rtl/benes_route_ctrl.sv
// Benes switch-setting generator: sequential looping algorithm, one input switch per cycle.
// Optional macro BENES_ROUTE_CHECK_EN adds the duplicate-destination CHECK state and err path.
module benes_route_ctrl #(
    parameter int SIZE = 8
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      perm_valid_i,
    output logic                                      perm_ready_o,
    input  logic [SIZE*$clog2(SIZE)-1:0]              perm_dst_i,
    output logic                                      ctrl_valid_o,
    input  logic                                      ctrl_ready_i,
    output logic [(2*$clog2(SIZE)-1)*(SIZE/2)-1:0]    ctrl_bits_o,
    output logic                                      err_o
);
    localparam int LW  = $clog2(SIZE);
    localparam int SW  = SIZE / 2;
    localparam int ST  = 2 * LW - 1;
    localparam int KW  = LW - 1;
    localparam int SLW = $clog2(ST);

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef BENES_ROUTE_CHECK_EN
        S_CHECK,
`endif
        S_LOOP,
        S_MID,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [LW-1:0]        wp_q  [SIZE];
    logic [LW-1:0]        wp_d  [SIZE];
    logic [LW-1:0]        nwp_q [SIZE];
    logic [LW-1:0]        nwp_d [SIZE];
    logic [SW-1:0]        set_q, set_d;
    logic [KW-1:0]        cur_q, cur_d;
    logic                 cur_c_q, cur_c_d;
    logic [SLW-1:0]       lvl_q, lvl_d;
    logic [KW-1:0]        cnt_q, cnt_d;
    logic [ST-1:0][SW-1:0] sw_q, sw_d;
    logic [ST-1:0][SW-1:0] ctrl_q, ctrl_d;
    logic                 err_q, err_d;

    // Per-cycle looping step for the current input switch
    logic [LW-1:0] h_sh, sub_sh;
    logic [KW-1:0] cur_j, cur_m, mmask, ou, og, cand, free_k;
    logic [LW-1:0] du, dl, tgt, xg, up_pos, lo_pos;
    logic [SW-1:0] set_now;
    logic [SLW-1:0] out_st;
    logic          found;

    always_comb begin
        h_sh   = LW'(KW) - LW'(lvl_q);
        sub_sh = h_sh + LW'(1);
        cur_j  = cur_q >> h_sh;
        mmask  = KW'((LW'(1) << h_sh) - LW'(1));
        cur_m  = cur_q & mmask;
        du     = cur_c_q ? wp_q[{cur_q, 1'b1}] : wp_q[{cur_q, 1'b0}];
        dl     = cur_c_q ? wp_q[{cur_q, 1'b0}] : wp_q[{cur_q, 1'b1}];
        ou     = du[LW-1:1];
        og     = (cur_j << h_sh) | ou;
        tgt    = du ^ LW'(1);
        // The input that must reach the partner output of og, restricted to this subnet
        found  = 1'b0;
        xg     = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (!found && ((LW'(i) >> sub_sh) == {1'b0, cur_j}) && (wp_q[i] == tgt)) begin
                found = 1'b1;
                xg    = LW'(i);
            end
        end
        cand    = xg[LW-1:1];
        set_now = set_q | (SW'(1) << cur_q);
        free_k  = '0;
        for (int k = SW - 1; k >= 0; k--) begin
            if (!set_now[k]) free_k = KW'(k);
        end
        up_pos = ({1'b0, cur_j} << sub_sh) | {1'b0, cur_m};
        lo_pos = up_pos | (LW'(1) << h_sh);
        out_st = SLW'(ST - 1) - lvl_q;
    end

`ifdef BENES_ROUTE_CHECK_EN
    logic [SIZE-1:0] seen;
    logic            dup;
`endif

    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        nwp_d   = nwp_q;
        set_d   = set_q;
        cur_d   = cur_q;
        cur_c_d = cur_c_q;
        lvl_d   = lvl_q;
        cnt_d   = cnt_q;
        sw_d    = sw_q;
        ctrl_d  = ctrl_q;
        err_d   = err_q;
`ifdef BENES_ROUTE_CHECK_EN
        seen    = '0;
        dup     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (perm_valid_i) begin
                    for (int i = 0; i < SIZE; i++) wp_d[i] = perm_dst_i[i*LW +: LW];
                    set_d   = '0;
                    cur_d   = '0;
                    cur_c_d = 1'b0;
                    lvl_d   = '0;
                    cnt_d   = '0;
                    sw_d    = '0;
                    err_d   = 1'b0;
`ifdef BENES_ROUTE_CHECK_EN
                    state_d = S_CHECK;
`else
                    state_d = S_LOOP;
`endif
                end
            end
`ifdef BENES_ROUTE_CHECK_EN
            S_CHECK: begin
                for (int i = 0; i < SIZE; i++) begin
                    if (seen[wp_q[i]]) dup = 1'b1;
                    seen[wp_q[i]] = 1'b1;
                end
                if (dup) begin
                    ctrl_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOOP;
                end
            end
`endif
            S_LOOP: begin
                sw_d[lvl_q][cur_q] = cur_c_q;
                sw_d[out_st][og]   = du[0];
                nwp_d[up_pos]      = du >> 1;
                nwp_d[lo_pos]      = dl >> 1;
                set_d              = set_now;
                // Follow the loop while it stays open; otherwise start a new loop straight
                if (found && !set_now[cand]) begin
                    cur_d   = cand;
                    cur_c_d = ~xg[0];
                end else begin
                    cur_d   = free_k;
                    cur_c_d = 1'b0;
                end
                cnt_d = cnt_q + KW'(1);
                if (cnt_q == KW'(SW - 1)) begin
                    wp_d    = nwp_d;
                    set_d   = '0;
                    cur_d   = '0;
                    cur_c_d = 1'b0;
                    cnt_d   = '0;
                    lvl_d   = lvl_q + SLW'(1);
                    if (lvl_q == SLW'(LW - 2)) state_d = S_MID;
                end
            end
            S_MID: begin
                ctrl_d = sw_q;
                for (int k = 0; k < SW; k++) ctrl_d[LW-1][k] = wp_q[2*k][0];
                state_d = S_DONE;
            end
            S_DONE: begin
                if (ctrl_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            for (int i = 0; i < SIZE; i++) begin
                wp_q[i]  <= '0;
                nwp_q[i] <= '0;
            end
            set_q   <= '0;
            cur_q   <= '0;
            cur_c_q <= 1'b0;
            lvl_q   <= '0;
            cnt_q   <= '0;
            sw_q    <= '0;
            ctrl_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            nwp_q   <= nwp_d;
            set_q   <= set_d;
            cur_q   <= cur_d;
            cur_c_q <= cur_c_d;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
            sw_q    <= sw_d;
            ctrl_q  <= ctrl_d;
            err_q   <= err_d;
        end
    end

    assign perm_ready_o = (state_q == S_IDLE) && !rst_i;
    assign ctrl_valid_o = (state_q == S_DONE);
    assign ctrl_bits_o  = ctrl_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_benes_route_ctrl.sv
// Directed and random permutation bench for benes_route_ctrl with an independent network model.
`timescale 1ns/1ps
module tb_benes_route_ctrl;
    localparam int SIZE = 8;
    localparam int LW   = 3;
    localparam int SW   = 4;
    localparam int ST   = 5;
    localparam int CW   = ST * SW;
    localparam int PW   = SIZE * LW;
`ifdef BENES_ROUTE_CHECK_EN
    localparam int LAT      = 10;
    localparam int DUP_LAT  = 1;
    localparam int DUP_ERR  = 1;
`else
    localparam int LAT      = 9;
    localparam int DUP_LAT  = 9;
    localparam int DUP_ERR  = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          perm_valid;
    logic          perm_ready;
    logic [PW-1:0] perm_dst;
    logic          ctrl_valid;
    logic          ctrl_ready;
    logic [CW-1:0] ctrl_bits;
    logic          err;

    always #5 clk = ~clk;

    benes_route_ctrl #(.SIZE(SIZE)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .perm_valid_i (perm_valid),
        .perm_ready_o (perm_ready),
        .perm_dst_i   (perm_dst),
        .ctrl_valid_o (ctrl_valid),
        .ctrl_ready_i (ctrl_ready),
        .ctrl_bits_o  (ctrl_bits),
        .err_o        (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk(input int v[SIZE]);
        logic [PW-1:0] r;
        r = '0;
        for (int i = 0; i < SIZE; i++) r[i*LW +: LW] = LW'(v[i]);
        return r;
    endfunction

    // Pushes input labels through the recursively wired network; counts inputs not at their target.
    function automatic int misroutes(input logic [CW-1:0] cb, input logic [PW-1:0] dst);
        int pos[SIZE];
        int nxt[SIZE];
        int tmp, bad, n, q, base, np;
        for (int i = 0; i < SIZE; i++) pos[i] = i;
        for (int s = 0; s < ST; s++) begin
            for (int k = 0; k < SW; k++) begin
                if (cb[s*SW+k]) begin
                    tmp = pos[2*k]; pos[2*k] = pos[2*k+1]; pos[2*k+1] = tmp;
                end
            end
            if (s < ST - 1) begin
                for (int p = 0; p < SIZE; p++) begin
                    if (s < LW - 1) begin
                        n = SIZE >> s; base = p - (p % n); q = p % n;
                        np = base + (q % 2) * (n / 2) + q / 2;
                    end else begin
                        n = SIZE >> (ST - 2 - s); base = p - (p % n); q = p % n;
                        np = base + 2 * (q % (n / 2)) + q / (n / 2);
                    end
                    nxt[np] = pos[p];
                end
                pos = nxt;
            end
        end
        bad = 0;
        for (int i = 0; i < SIZE; i++) if (pos[dst[i*LW +: LW]] != i) bad++;
        return bad;
    endfunction

    task automatic run_txn(input string tag, input logic [PW-1:0] dst, input int hold,
                           output logic [CW-1:0] bits, output logic e, output int lat);
        int waitc;
        waitc = 0;
        while (!perm_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check_eq({tag, "_ready_in"}, perm_ready, 1);
        perm_dst   = dst;
        perm_valid = 1'b1;
        @(negedge clk);
        perm_valid = 1'b0;
        perm_dst   = PW'($urandom);
        lat = 0;
        while (!ctrl_valid && lat < 40) begin
            check_eq({tag, "_busy"}, perm_ready, 0);
            ctrl_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        bits = ctrl_bits;
        e    = err;
        ctrl_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq({tag, "_hold_bits"}, ctrl_bits, bits);
            check_eq({tag, "_hold_err"}, err, e);
            check_eq({tag, "_hold_valid"}, ctrl_valid, 1);
            check_eq({tag, "_hold_pready"}, perm_ready, 0);
        end
        ctrl_ready = 1'b1;
        @(negedge clk);
        ctrl_ready = 1'b0;
        check_eq({tag, "_valid_drop"}, ctrl_valid, 0);
        check_eq({tag, "_ready_back"}, perm_ready, 1);
        $display("txn %s dst=%h ctrl=%h err=%0d lat=%0d", tag, dst, bits, e, lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            v[SIZE];
        int            lat, j, tmp;
        logic [CW-1:0] b;
        logic          e;
        logic [PW-1:0] d;

        rst = 1'b1; perm_valid = 1'b0; perm_dst = '0; ctrl_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", ctrl_valid, 0);
        check_eq("rst_bits", ctrl_bits, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_pready", perm_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_pready", perm_ready, 1);

        v = '{0, 1, 2, 3, 4, 5, 6, 7};
        d = mk(v);
        run_txn("identity", d, 0, b, e, lat);
        check_eq("identity_lat", lat, LAT);
        check_eq("identity_bits", b, 20'h00000);
        check_eq("identity_err", e, 0);

        v = '{7, 6, 5, 4, 3, 2, 1, 0};
        d = mk(v);
        run_txn("reversal_bp", d, 5, b, e, lat);
        check_eq("reversal_lat", lat, LAT);
        check_eq("reversal_bits", b, 20'hFFF00);
        check_eq("reversal_err", e, 0);
        check_eq("reversal_route", misroutes(b, d), 0);

        v = '{1, 0, 2, 3, 4, 5, 6, 7};
        d = mk(v);
        run_txn("swap01", d, 1, b, e, lat);
        check_eq("swap01_lat", lat, LAT);
        check_eq("swap01_bits", b, 20'h10000);
        check_eq("swap01_route", misroutes(b, d), 0);

        v = '{7, 6, 5, 4, 3, 2, 0, 0};
        d = mk(v);
        run_txn("duplicate", d, 2, b, e, lat);
        check_eq("duplicate_lat", lat, DUP_LAT);
        check_eq("duplicate_err", e, DUP_ERR);
`ifdef BENES_ROUTE_CHECK_EN
        check_eq("duplicate_bits", b, 0);
`endif

        // Abort mid-computation with reset while a reversal result is still on ctrl_bits
        v = '{7, 6, 5, 4, 3, 2, 1, 0};
        d = mk(v);
        run_txn("reversal2", d, 0, b, e, lat);
        check_eq("reversal2_bits", b, 20'hFFF00);
        v = '{1, 0, 2, 3, 4, 5, 6, 7};
        perm_dst = mk(v);
        perm_valid = 1'b1;
        @(negedge clk);
        perm_valid = 1'b0;
        repeat (LAT - 6) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midrst_valid", ctrl_valid, 0);
        check_eq("midrst_bits", ctrl_bits, 0);
        check_eq("midrst_err", err, 0);
        check_eq("midrst_pready", perm_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_release_pready", perm_ready, 1);
        v = '{0, 1, 2, 3, 4, 5, 6, 7};
        d = mk(v);
        run_txn("identity_after_rst", d, 0, b, e, lat);
        check_eq("identity2_lat", lat, LAT);
        check_eq("identity2_bits", b, 20'h00000);

        for (int t = 0; t < 500; t++) begin
            for (int i = 0; i < SIZE; i++) v[i] = i;
            for (int i = SIZE - 1; i > 0; i--) begin
                j = int'($urandom_range(0, i));
                tmp = v[i]; v[i] = v[j]; v[j] = tmp;
            end
            d = mk(v);
            run_txn($sformatf("rand%0d", t), d, int'($urandom_range(0, 3)), b, e, lat);
            check_eq($sformatf("rand%0d_lat", t), lat, LAT);
            check_eq($sformatf("rand%0d_err", t), e, 0);
            check_eq($sformatf("rand%0d_route", t), misroutes(b, d), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
